// File: rtl/confreg_uart_tx.sv
// confreg_uart_tx: serializes bytes written to the config-register VUART
// address as 8N1 asynchronous serial through a small TX FIFO.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   wr_valid     - one-cycle write strobe from the config register block
//   wr_data      - byte to queue, sampled with wr_valid
//   ovf_clr      - one-cycle pulse clearing the sticky overflow flag
//   uart_txd     - registered serial output, idle high
//   busy         - registered, high while a frame is in progress
//   fifo_count   - entries currently queued
//   fifo_full    - fifo_count == FIFO_DEPTH
//   overflow     - sticky: a write was dropped because the FIFO was full
module confreg_uart_tx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  input  logic                          ovf_clr,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [BAUD_W-1:0] baud_q,   baud_d;
  logic [2:0]        bit_q,    bit_d;
  logic [7:0]        shift_q,  shift_d;
  logic              txd_q,    txd_d;
  logic              busy_q,   busy_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              full_q,   full_d;
  logic              ovf_q,    ovf_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic baud_wrap;

  // Next-state logic for the FIFO bookkeeping and the serializer FSM.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;

    // Acceptance uses the count registered at the start of the cycle, so a
    // write into a full FIFO is dropped even when a pop happens alongside.
    push      = wr_valid && (count_q != CNT_W'(FIFO_DEPTH));
    pop       = (state_q == S_IDLE) && (count_q != '0);
    baud_wrap = (baud_q == BAUD_W'(CLK_DIV - 1));

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      S_START: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state held during the cycle, so the pin lags
    // the FSM by one edge (start bit appears one edge after the pop).
    case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));

    // A dropped write takes priority over a same-cycle clear.
    if (wr_valid && !push) ovf_d = 1'b1;
    else if (ovf_clr)      ovf_d = 1'b0;
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign uart_txd   = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_confreg_uart_tx.sv
// tb_confreg_uart_tx: drives directed and random traffic into confreg_uart_tx
// and compares every output, every cycle, against a transaction-level model
// (byte queue plus frame start times).
module tb_confreg_uart_tx;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       uart_txd;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       fifo_full;
  logic       overflow;

  confreg_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .ovf_clr    (ovf_clr),
    .uart_txd   (uart_txd),
    .busy       (busy),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: queued bytes, the byte in flight, and the edge at which it was popped.
  logic [7:0] q_m[$];
  logic [7:0] cur_m = 8'h00;
  bit         act_m = 1'b0;
  bit         ovf_m = 1'b0;
  int         p_m   = 0;
  int         e_m   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e_m, obs, exp);
    end
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input bit wr, input logic [7:0] d, input bit clr, input bit r);
    int  o;
    bit  idle_pre;
    bit  acc;
    e_m++;
    if (r) begin
      q_m.delete();
      act_m = 1'b0;
      ovf_m = 1'b0;
      return;
    end
    o        = e_m - p_m;
    idle_pre = !(act_m && o >= 1 && o <= int'(FRAME));
    acc      = wr && (q_m.size() < int'(DEPTH));
    if (wr && !acc) ovf_m = 1'b1;
    else if (clr)   ovf_m = 1'b0;
    if (idle_pre && q_m.size() != 0) begin
      cur_m = q_m.pop_front();
      p_m   = e_m;
      act_m = 1'b1;
    end
    if (acc) q_m.push_back(d);
  endtask

  // Expected line level: start bit, 8 data bits LSB first, stop bit, each D
  // cycles, beginning one edge after the pop edge.
  function automatic logic exp_txd();
    int o;
    int k;
    o = e_m - p_m;
    if (!act_m || o < 1 || o > int'(FRAME)) return 1'b1;
    k = (o - 1) / int'(D);
    if (k == 0) return 1'b0;
    if (k <= 8) return cur_m[k-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    int o;
    o = e_m - p_m;
    return act_m && o >= 0 && o < int'(FRAME);
  endfunction

  task automatic tick(input bit wr, input logic [7:0] d, input bit clr, input bit r);
    @(negedge clk);
    wr_valid = wr;
    wr_data  = d;
    ovf_clr  = clr;
    rst      = r;
    @(posedge clk);
    model_step(wr, d, clr, r);
    #1;
    chk("uart_txd",   32'(uart_txd),   32'(exp_txd()));
    chk("busy",       32'(busy),       32'(exp_busy()));
    chk("fifo_count", 32'(fifo_count), 32'(q_m.size()));
    chk("fifo_full",  32'(fifo_full),  32'(q_m.size() == int'(DEPTH)));
    chk("overflow",   32'(overflow),   32'(ovf_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);

    // Single byte
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(50);

    // Back-to-back burst
    tick(1'b1, 8'h01, 1'b0, 1'b0);
    tick(1'b1, 8'h02, 1'b0, 1'b0);
    tick(1'b1, 8'h03, 1'b0, 1'b0);
    idle(135);

    // Overflow, then clear with a simultaneous dropped write, then clear alone
    for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    tick(1'b1, 8'h77, 1'b1, 1'b0);
    idle(2);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    idle(5 * (FRAME + 1) + 10);

    // Reset in the middle of data bit 3 with bytes still queued
    for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(15);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(50);
    tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(FRAME + 5);

    // Pointer wrap: 12 paced bytes
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      idle(FRAME + 4);
    end

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 7) == 0, 8'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
    end
    idle(6 * (FRAME + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/confreg_uart_tx.md
Name: confreg_uart_tx

Overview:
- Downstream consumer of the config-register virtual-UART write strobe.
- Each accepted CPU write to the VUART address delivers one byte. The byte is buffered in a small FIFO and serialized as 8N1 asynchronous serial on a board pin.
- Sits beside the config register block in the SoC top; its status is readable back through the config register read mux.

Parameters:
- CLK_DIV, 868, clock cycles per serial bit period (868 = 100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, byte entries in the TX FIFO; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  one-cycle write strobe; equals conf_en && conf_wen!=0 && addr==VUART.
- wr_data  input  8  byte to transmit; sampled when wr_valid=1.
- ovf_clr  input  1  one-cycle pulse that clears the overflow flag.
- uart_txd  output  1  serial output; idle high; registered.
- busy  output  1  1 whenever the FSM is not IDLE; registered.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries currently held.
- fifo_full  output  1  fifo_count==FIFO_DEPTH.
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, 1 cycle): uart_txd=1, busy=0, FSM=IDLE, FIFO emptied (pointers=0, fifo_count=0), fifo_full=0, overflow=0, baud counter=0, bit index=0.
- Reset mid-frame: the frame is aborted, uart_txd=1 on the next edge, and all FIFO contents are discarded.
- FIFO push:
  - A push is accepted iff wr_valid=1 and fifo_count<FIFO_DEPTH, using the count registered at the start of that cycle.
  - A write while full is dropped; the FIFO is unchanged and overflow is set to 1.
- FIFO pop: occurs only in IDLE when fifo_count!=0. The head entry is loaded into the shift register.
- Count arithmetic: a simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- A push into a full FIFO is rejected even if a pop occurs in the same cycle.
- overflow: if set and ovf_clr occur in the same cycle, set wins (overflow=1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_txd=1. If fifo_count!=0: pop, baud counter←0, go to START.
  - START: uart_txd=0 for CLK_DIV cycles, then go to DATA with bit index=0.
  - DATA: uart_txd=shift[0] for CLK_DIV cycles per bit; shift right after each bit, LSB first. After bit 7, go to STOP.
  - STOP: uart_txd=1 for CLK_DIV cycles, then go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 and wraps at CLK_DIV-1. Each wrap advances the bit or state.
- Latency:
  - A push at edge t into an empty FIFO gives fifo_count=1 after t.
  - The pop occurs at edge t+1.
  - uart_txd falls after edge t+2.
- Frame timing: 10*CLK_DIV cycles per frame. Back-to-back frames have exactly 1 idle-high cycle (the IDLE pop cycle) between stop bit and next start bit.
- No backpressure reaches the CPU; the FIFO never stalls the config register path.

Test Plan:
- Single byte, CLK_DIV=4: push 0xA5 at cycle 0.
  -> uart_txd=1 through cycle 2, then low for cycles 3–6 (start bit).
  -> Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
  -> busy high for 40 cycles; fifo_count 1→0 at the pop.
- Burst, CLK_DIV=4: push 0x01, 0x02, 0x03 on consecutive cycles.
  -> Three frames each 40 cycles, separated by a single 1-cycle high gap.
  -> Decoded bytes are in order 01, 02, 03; fifo_count peaks at 2.
- Overflow, FIFO_DEPTH=4: push 6 bytes on consecutive cycles from idle.
  -> 5 bytes accepted (first popped at cycle 1); 6th dropped; fifo_full=1; overflow=1.
  -> The 5 transmitted bytes match the first 5 written.
- Overflow clear: hold overflow=1, assert ovf_clr alone.
  -> overflow=0 next cycle.
  -> With the FIFO full, assert ovf_clr and wr_valid together: overflow stays 1 and the count is unchanged.
- Reset mid-frame: rst during DATA bit 3 with 2 bytes queued.
  -> uart_txd=1, busy=0, fifo_count=0 next cycle; no further frames.
  -> A new push after reset transmits correctly.
- Pointer wrap, FIFO_DEPTH=4: stream 12 bytes 0x10..0x1B, pacing each write only after the previous frame's start bit.
  -> All 12 bytes received in order; overflow stays 0.
